pe_sad_acc: RTL and testbench

Parametrised motion-estimation processing element for the DMT SAD array. It holds NUM_CB current-block pixels in a ping-pong register bank, so the next block preloads while the current one is compared. It selects one of four adjacent reference-pixel sources and computes the absolute difference. A pipelined accumulator turns ACC_LEN differences into one SAD result. Instances chain through the current-pixel forward port and the reference-pixel ports.

---
 rtl/pe_sad_pkg.sv | 20 ++
 rtl/pe_cb_bank.sv | 45 ++++
 rtl/pe_sad_acc.sv | 180 ++++++++++++++++++
 tb/tb_pe_sad_acc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_sad_pkg.sv
// Shared definitions for the SAD processing element: reference-source
// encodings, accumulator FSM states and the accumulator width helper.
package pe_sad_pkg;

    localparam logic [1:0] REF_UP1 = 2'b00;
    localparam logic [1:0] REF_UP8 = 2'b01;
    localparam logic [1:0] REF_DN1 = 2'b10;
    localparam logic [1:0] REF_DN8 = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;

    // One guard bit on top of log2(window) keeps ACC_LEN*(2^PIXEL_W-1) in range.
    function automatic int acc_width(input int pixel_w, input int acc_len);
        return pixel_w + $clog2(acc_len) + 1;
    endfunction

endpackage

// File: rtl/pe_cb_bank.sv
// Ping-pong current-block storage: writes go to the shadow bank while the
// active bank feeds the comparator; a swap flips which bank is active.
module pe_cb_bank #(
    parameter int PIXEL_W = 8,
    parameter int NUM_CB  = 4,
    parameter int IDX_W   = $clog2(NUM_CB)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [PIXEL_W-1:0] i_data,
    input  logic               i_swap,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic [PIXEL_W-1:0] o_rd_data
);

    logic [PIXEL_W-1:0] r_bank_a [NUM_CB];
    logic [PIXEL_W-1:0] r_bank_b [NUM_CB];
    logic               r_active;

    // The write uses the pre-swap active bit, so a write coinciding with a
    // swap lands in the bank that is about to become active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CB; i++) begin
                r_bank_a[i] <= '0;
                r_bank_b[i] <= '0;
            end
            r_active <= 1'b0;
        end else begin
            if (i_we) begin
                if (r_active)
                    r_bank_a[i_idx] <= i_data;
                else
                    r_bank_b[i_idx] <= i_data;
            end
            if (i_swap)
                r_active <= ~r_active;
        end
    end

    assign o_rd_data = r_active ? r_bank_b[i_rd_idx] : r_bank_a[i_rd_idx];

endmodule

// File: rtl/pe_sad_acc.sv
// Motion-estimation PE: reference mux, absolute difference against the
// active current-block bank, and a pipelined windowed SAD accumulator.
module pe_sad_acc
    import pe_sad_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int NUM_CB  = 4,
    parameter int ACC_LEN = 16,
    parameter int IDX_W   = $clog2(NUM_CB),
    parameter int ACC_W   = acc_width(PIXEL_W, ACC_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIXEL_W-1:0] i_cur_in,
    input  logic               i_cur_we,
    input  logic [IDX_W-1:0]   i_cur_idx,
    output logic [PIXEL_W-1:0] o_cur_fwd,
    output logic               o_cur_fwd_we,
    input  logic               i_bank_swap,
    input  logic [PIXEL_W-1:0] i_ref_up1,
    input  logic [PIXEL_W-1:0] i_ref_up8,
    input  logic [PIXEL_W-1:0] i_ref_dn1,
    input  logic [PIXEL_W-1:0] i_ref_dn8,
    input  logic               i_ref_en,
    input  logic [1:0]         i_ref_sel,
    output logic [PIXEL_W-1:0] o_ref_pix,
    input  logic [IDX_W-1:0]   i_cmp_idx,
    input  logic               i_cmp_valid,
    input  logic               i_acc_start,
    output logic [PIXEL_W-1:0] o_abs_out,
    output logic [ACC_W-1:0]   o_sad_out,
    output logic               o_sad_valid
);

    localparam int             CNT_W    = $clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic [PIXEL_W-1:0] w_ref_src;
    logic [PIXEL_W-1:0] w_cur_pix;
    logic [PIXEL_W-1:0] r_ref_pix;
    logic [PIXEL_W-1:0] r_cur_fwd;
    logic               r_cur_fwd_we;
    logic [PIXEL_W-1:0] r_d1;
    logic               r_v1;
    logic               r_s1;
    logic [ACC_W-1:0]   w_d1_ext;
    logic [ACC_W-1:0]   w_sum;
    acc_state_e         r_state;
    acc_state_e         w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [ACC_W-1:0]   r_sad;
    logic [ACC_W-1:0]   w_sad_next;
    logic               r_sad_valid;
    logic               w_sad_valid_next;

    pe_cb_bank #(
        .PIXEL_W (PIXEL_W),
        .NUM_CB  (NUM_CB),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (i_cur_we),
        .i_idx     (i_cur_idx),
        .i_data    (i_cur_in),
        .i_swap    (i_bank_swap),
        .i_rd_idx  (i_cmp_idx),
        .o_rd_data (w_cur_pix)
    );

    always_comb begin
        case (i_ref_sel)
            REF_UP1: w_ref_src = i_ref_up1;
            REF_UP8: w_ref_src = i_ref_up8;
            REF_DN1: w_ref_src = i_ref_dn1;
            default: w_ref_src = i_ref_dn8;
        endcase
    end

    assign o_abs_out = (w_cur_pix >= r_ref_pix) ? (w_cur_pix - r_ref_pix)
                                                : (r_ref_pix - w_cur_pix);
    assign w_d1_ext  = ACC_W'(r_d1);
    assign w_sum     = r_acc + w_d1_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_pix    <= '0;
            r_cur_fwd    <= '0;
            r_cur_fwd_we <= 1'b0;
            r_d1         <= '0;
            r_v1         <= 1'b0;
            r_s1         <= 1'b0;
        end else begin
            if (i_ref_en)
                r_ref_pix <= w_ref_src;
            if (i_cur_we)
                r_cur_fwd <= i_cur_in;
            r_cur_fwd_we <= i_cur_we;
            r_d1         <= o_abs_out;
            r_v1         <= i_cmp_valid;
            r_s1         <= i_acc_start & i_cmp_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (r_v1 && r_s1) w_state_next = ACC;
            ACC:     if (r_v1 && !r_s1 && r_cnt == CNT_LAST) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A start seen while accumulating discards the partial sum silently.
    always_comb begin
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        w_sad_next       = r_sad;
        w_sad_valid_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_v1 && r_s1) begin
                    w_acc_next = w_d1_ext;
                    w_cnt_next = CNT_W'(1);
                end
            end
            ACC: begin
                if (r_v1) begin
                    if (r_s1) begin
                        w_acc_next = w_d1_ext;
                        w_cnt_next = CNT_W'(1);
                    end else if (r_cnt == CNT_LAST) begin
                        w_sad_next       = w_sum;
                        w_sad_valid_next = 1'b1;
                        w_acc_next       = '0;
                        w_cnt_next       = '0;
                    end else begin
                        w_acc_next = w_sum;
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_acc_next = '0;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sad       <= '0;
            r_sad_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_sad       <= w_sad_next;
            r_sad_valid <= w_sad_valid_next;
        end
    end

    assign o_ref_pix    = r_ref_pix;
    assign o_cur_fwd    = r_cur_fwd;
    assign o_cur_fwd_we = r_cur_fwd_we;
    assign o_sad_out    = r_sad;
    assign o_sad_valid  = r_sad_valid;

endmodule

// File: tb/tb_pe_sad_acc.sv
// Directed bench for pe_sad_acc: default instance plus an NUM_CB=8 /
// ACC_LEN=64 instance for the wide-window case.
module tb_pe_sad_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cur_in;
    logic        cur_we;
    logic [1:0]  cur_idx;
    logic [7:0]  cur_fwd;
    logic        cur_fwd_we;
    logic        bank_swap;
    logic [7:0]  ref_up1, ref_up8, ref_dn1, ref_dn8;
    logic        ref_en;
    logic [1:0]  ref_sel;
    logic [7:0]  ref_pix;
    logic [1:0]  cmp_idx;
    logic        cmp_valid;
    logic        acc_start;
    logic [7:0]  abs_out;
    logic [12:0] sad_out;
    logic        sad_valid;

    logic [7:0]  b_cur_in;
    logic        b_cur_we;
    logic [2:0]  b_cur_idx;
    logic [7:0]  b_cur_fwd;
    logic        b_cur_fwd_we;
    logic        b_bank_swap;
    logic [7:0]  b_ref_dn1;
    logic        b_ref_en;
    logic [1:0]  b_ref_sel;
    logic [7:0]  b_ref_pix;
    logic [2:0]  b_cmp_idx;
    logic        b_cmp_valid;
    logic        b_acc_start;
    logic [7:0]  b_abs_out;
    logic [14:0] b_sad_out;
    logic        b_sad_valid;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int pulseMark;

    always #5 clk = ~clk;

    pe_sad_acc dut (
        .clk(clk), .rst_n(rst_n),
        .i_cur_in(cur_in), .i_cur_we(cur_we), .i_cur_idx(cur_idx),
        .o_cur_fwd(cur_fwd), .o_cur_fwd_we(cur_fwd_we),
        .i_bank_swap(bank_swap),
        .i_ref_up1(ref_up1), .i_ref_up8(ref_up8), .i_ref_dn1(ref_dn1), .i_ref_dn8(ref_dn8),
        .i_ref_en(ref_en), .i_ref_sel(ref_sel), .o_ref_pix(ref_pix),
        .i_cmp_idx(cmp_idx), .i_cmp_valid(cmp_valid), .i_acc_start(acc_start),
        .o_abs_out(abs_out), .o_sad_out(sad_out), .o_sad_valid(sad_valid)
    );

    pe_sad_acc #(.PIXEL_W(8), .NUM_CB(8), .ACC_LEN(64)) dutWide (
        .clk(clk), .rst_n(rst_n),
        .i_cur_in(b_cur_in), .i_cur_we(b_cur_we), .i_cur_idx(b_cur_idx),
        .o_cur_fwd(b_cur_fwd), .o_cur_fwd_we(b_cur_fwd_we),
        .i_bank_swap(b_bank_swap),
        .i_ref_up1(8'd9), .i_ref_up8(8'd9), .i_ref_dn1(b_ref_dn1), .i_ref_dn8(8'd9),
        .i_ref_en(b_ref_en), .i_ref_sel(b_ref_sel), .o_ref_pix(b_ref_pix),
        .i_cmp_idx(b_cmp_idx), .i_cmp_valid(b_cmp_valid), .i_acc_start(b_acc_start),
        .o_abs_out(b_abs_out), .o_sad_out(b_sad_out), .o_sad_valid(b_sad_valid)
    );

    always @(negedge clk) begin
        if (sad_valid === 1'b1)
            pulses++;
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic feed(input int n, input bit startFirst);
        for (int i = 0; i < n; i++) begin
            cmp_valid = 1'b1;
            acc_start = startFirst && (i == 0);
            cmp_idx   = 2'(i % 4);
            applyStimulus(1);
        end
        cmp_valid = 1'b0;
        acc_start = 1'b0;
    endtask

    // Last sample sits in stage 1 on entry; the pulse follows one edge later.
    task automatic expectSad(input string tag, input int expected);
        checkOutput({tag, "_pre_valid"}, 32'(sad_valid), 32'd0);
        applyStimulus(1);
        checkOutput({tag, "_valid"}, 32'(sad_valid), 32'd1);
        checkOutput({tag, "_sad"}, 32'(sad_out), 32'(expected));
        applyStimulus(1);
        checkOutput({tag, "_valid_drop"}, 32'(sad_valid), 32'd0);
        checkOutput({tag, "_sad_hold"}, 32'(sad_out), 32'(expected));
    endtask

    task automatic writeShadow(input int value);
        for (int i = 0; i < 4; i++) begin
            cur_we  = 1'b1;
            cur_idx = 2'(i);
            cur_in  = 8'(value);
            applyStimulus(1);
        end
        cur_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cur_in = '0; cur_we = 1'b0; cur_idx = '0; bank_swap = 1'b0;
        ref_up1 = '0; ref_up8 = '0; ref_dn1 = '0; ref_dn8 = '0;
        ref_en = 1'b0; ref_sel = '0; cmp_idx = '0; cmp_valid = 1'b0; acc_start = 1'b0;
        b_cur_in = '0; b_cur_we = 1'b0; b_cur_idx = '0; b_bank_swap = 1'b0;
        b_ref_dn1 = '0; b_ref_en = 1'b0; b_ref_sel = '0;
        b_cmp_idx = '0; b_cmp_valid = 1'b0; b_acc_start = 1'b0;

        applyStimulus(2);
        checkOutput("rst_ref_pix", 32'(ref_pix), 32'd0);
        checkOutput("rst_cur_fwd", 32'(cur_fwd), 32'd0);
        checkOutput("rst_cur_fwd_we", 32'(cur_fwd_we), 32'd0);
        checkOutput("rst_sad_out", 32'(sad_out), 32'd0);
        checkOutput("rst_sad_valid", 32'(sad_valid), 32'd0);
        checkOutput("rst_abs_out", 32'(abs_out), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1);

        // Load 10/20/30/40 into the shadow bank, then swap and pick up1=25.
        cur_we = 1'b1; cur_idx = 2'd0; cur_in = 8'd10;
        applyStimulus(1);
        checkOutput("fwd_data", 32'(cur_fwd), 32'd10);
        checkOutput("fwd_we", 32'(cur_fwd_we), 32'd1);
        for (int i = 1; i < 4; i++) begin
            cur_idx = 2'(i);
            cur_in  = 8'(10 * (i + 1));
            applyStimulus(1);
        end
        cur_we = 1'b0;
        ref_up1 = 8'd25; ref_up8 = 8'd100; ref_dn1 = 8'd0; ref_dn8 = 8'd255;
        ref_sel = 2'b00; ref_en = 1'b1; bank_swap = 1'b1;
        applyStimulus(1);
        ref_en = 1'b0; bank_swap = 1'b0;
        checkOutput("fwd_we_drop", 32'(cur_fwd_we), 32'd0);
        checkOutput("ref_up1", 32'(ref_pix), 32'd25);
        cmp_idx = 2'd0; #1 checkOutput("abs_idx0", 32'(abs_out), 32'd15);
        cmp_idx = 2'd1; #1 checkOutput("abs_idx1", 32'(abs_out), 32'd5);
        cmp_idx = 2'd2; #1 checkOutput("abs_idx2", 32'(abs_out), 32'd5);
        cmp_idx = 2'd3; #1 checkOutput("abs_idx3", 32'(abs_out), 32'd15);

        ref_sel = 2'b01; ref_en = 1'b1; applyStimulus(1); ref_en = 1'b0;
        checkOutput("ref_up8", 32'(ref_pix), 32'd100);
        cmp_idx = 2'd1; #1 checkOutput("abs_up8_idx1", 32'(abs_out), 32'd80);
        ref_sel = 2'b10; ref_en = 1'b1; applyStimulus(1); ref_en = 1'b0;
        checkOutput("ref_dn1", 32'(ref_pix), 32'd0);
        cmp_idx = 2'd2; #1 checkOutput("abs_dn1_idx2", 32'(abs_out), 32'd30);
        ref_sel = 2'b11; ref_en = 1'b1; applyStimulus(1); ref_en = 1'b0;
        checkOutput("ref_dn8", 32'(ref_pix), 32'd255);
        cmp_idx = 2'd3; #1 checkOutput("abs_dn8_idx3", 32'(abs_out), 32'd215);
        ref_dn8 = 8'd1; ref_sel = 2'b00;
        applyStimulus(1);
        checkOutput("ref_hold", 32'(ref_pix), 32'd255);

        // Full window: all 200 against 0.
        writeShadow(200);
        ref_dn1 = 8'd0; ref_sel = 2'b10; ref_en = 1'b1; bank_swap = 1'b1;
        applyStimulus(1);
        ref_en = 1'b0; bank_swap = 1'b0;
        cmp_idx = 2'd0; #1 checkOutput("abs_200", 32'(abs_out), 32'd200);
        pulseMark = pulses;
        feed(16, 1'b1);
        expectSad("full", 3200);
        checkOutput("full_one_pulse", 32'(pulses - pulseMark), 32'd1);

        // Window with a 3-cycle gap against ref 100.
        ref_sel = 2'b01; ref_en = 1'b1; applyStimulus(1); ref_en = 1'b0;
        feed(8, 1'b1);
        applyStimulus(3);
        feed(8, 1'b0);
        expectSad("gap", 1600);

        // Restart at sample 9: only the second window reports.
        ref_dn8 = 8'd50; ref_sel = 2'b11; ref_en = 1'b1; applyStimulus(1); ref_en = 1'b0;
        pulseMark = pulses;
        feed(8, 1'b1);
        feed(16, 1'b1);
        checkOutput("restart_no_early", 32'(pulses - pulseMark), 32'd0);
        expectSad("restart", 2400);
        checkOutput("restart_one_pulse", 32'(pulses - pulseMark), 32'd1);

        // Write and swap together: slot 1 of the new active bank reads 99.
        ref_sel = 2'b10; ref_en = 1'b1;
        cur_we = 1'b1; cur_idx = 2'd1; cur_in = 8'd99; bank_swap = 1'b1;
        applyStimulus(1);
        cur_we = 1'b0; bank_swap = 1'b0; ref_en = 1'b0;
        cmp_idx = 2'd1; #1 checkOutput("swapwr_idx1", 32'(abs_out), 32'd99);
        cmp_idx = 2'd0; #1 checkOutput("swapwr_idx0", 32'(abs_out), 32'd10);
        cur_we = 1'b1; cur_idx = 2'd1; cur_in = 8'd7;
        applyStimulus(1);
        cur_we = 1'b0;
        checkOutput("shadow_fwd", 32'(cur_fwd), 32'd7);
        cmp_idx = 2'd1; #1 checkOutput("shadow_no_effect", 32'(abs_out), 32'd99);

        // Reset in the middle of a window.
        feed(10, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ref_pix", 32'(ref_pix), 32'd0);
        checkOutput("midrst_sad_out", 32'(sad_out), 32'd0);
        checkOutput("midrst_sad_valid", 32'(sad_valid), 32'd0);
        checkOutput("midrst_cur_fwd", 32'(cur_fwd), 32'd0);
        checkOutput("midrst_abs_out", 32'(abs_out), 32'd0);
        applyStimulus(1);
        rst_n = 1'b1;
        pulseMark = pulses;
        applyStimulus(4);
        checkOutput("midrst_no_pulse", 32'(pulses - pulseMark), 32'd0);
        writeShadow(60);
        ref_dn1 = 8'd0; ref_sel = 2'b10; ref_en = 1'b1; bank_swap = 1'b1;
        applyStimulus(1);
        ref_en = 1'b0; bank_swap = 1'b0;
        feed(16, 1'b1);
        expectSad("post_rst", 960);

        // Wide instance: 64 samples of 255 against 0.
        for (int i = 0; i < 8; i++) begin
            b_cur_we = 1'b1; b_cur_idx = 3'(i); b_cur_in = 8'd255;
            applyStimulus(1);
        end
        b_cur_we = 1'b0;
        b_ref_dn1 = 8'd0; b_ref_sel = 2'b10; b_ref_en = 1'b1; b_bank_swap = 1'b1;
        applyStimulus(1);
        b_ref_en = 1'b0; b_bank_swap = 1'b0;
        b_cmp_idx = 3'd5; #1 checkOutput("wide_abs", 32'(b_abs_out), 32'd255);
        for (int i = 0; i < 64; i++) begin
            b_cmp_valid = 1'b1;
            b_acc_start = (i == 0);
            b_cmp_idx   = 3'(i % 8);
            applyStimulus(1);
        end
        b_cmp_valid = 1'b0; b_acc_start = 1'b0;
        checkOutput("wide_pre_valid", 32'(b_sad_valid), 32'd0);
        applyStimulus(1);
        checkOutput("wide_valid", 32'(b_sad_valid), 32'd1);
        checkOutput("wide_sad", 32'(b_sad_out), 32'd16320);
        applyStimulus(1);
        checkOutput("wide_valid_drop", 32'(b_sad_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
